// File: rtl/iagc_mem_sequencer.sv
// iagc_mem_sequencer: drives the IAGC sample BRAM for the top-level FSM.
// Performs decimated ADC capture, zero-fill, or byte-serial dump to the UART,
// and returns a one-cycle end pulse per finished operation. All outputs are
// registered; a status change away from the active code aborts immediately.
`timescale 1ns/1ps
module iagc_mem_sequencer #(
   parameter int unsigned STATUS_SIZE    = 4,
   parameter int unsigned ADDR_SIZE      = 12,
   parameter int unsigned DATA_SIZE      = 14,
   parameter int unsigned DECIMATOR_SIZE = 4,
   parameter int unsigned TX_SIZE        = 8
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic [STATUS_SIZE-1:0]    i_status,
   input  logic [ADDR_SIZE-1:0]      i_memory_size,
   input  logic [DECIMATOR_SIZE-1:0] i_decimator,
   input  logic                      i_adc_valid,
   input  logic [DATA_SIZE-1:0]      i_adc_data,
   input  logic [DATA_SIZE-1:0]      i_mem_rdata,
   input  logic                      i_tx_ready,
   output logic                      o_mem_we,
   output logic [ADDR_SIZE-1:0]      o_mem_addr,
   output logic [DATA_SIZE-1:0]      o_mem_wdata,
   output logic                      o_tx_valid,
   output logic [TX_SIZE-1:0]        o_tx_data,
   output logic                      o_sample_end,
   output logic                      o_dump_end,
   output logic                      o_clean_end,
   output logic                      o_busy
);

   // One extra bit so a limit of 2^ADDR_SIZE is representable.
   localparam int unsigned CntW = ADDR_SIZE + 1;

   localparam logic [STATUS_SIZE-1:0] CodeSample = STATUS_SIZE'(4'b0011);
   localparam logic [STATUS_SIZE-1:0] CodeDump   = STATUS_SIZE'(4'b0111);
   localparam logic [STATUS_SIZE-1:0] CodeClean  = STATUS_SIZE'(4'b1000);

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StClean,
      StDumpRd,
      StDumpWait,
      StDumpHi,
      StDumpLo,
      StDone
   } state_e;

   state_e                    state_q;
   logic [STATUS_SIZE-1:0]    op_q;
   logic [CntW-1:0]           limit_q;
   logic [CntW-1:0]           count_q;
   logic [DECIMATOR_SIZE-1:0] dec_n_q;
   logic [DECIMATOR_SIZE-1:0] dec_cnt_q;
   logic [7:0]                lo_byte_q;
   logic                      mem_we_q;
   logic [ADDR_SIZE-1:0]      mem_addr_q;
   logic [DATA_SIZE-1:0]      mem_wdata_q;
   logic                      tx_valid_q;
   logic [TX_SIZE-1:0]        tx_data_q;
   logic                      sample_end_q;
   logic                      dump_end_q;
   logic                      clean_end_q;
   logic                      busy_q;

   logic [CntW-1:0]           entry_limit;
   logic [DECIMATOR_SIZE-1:0] entry_dec;
   logic [CntW-1:0]           count_inc;
   logic                      last_word;
   logic [DECIMATOR_SIZE-1:0] dec_cnt_inc;
   logic                      dec_wrap;
   logic [TX_SIZE-1:0]        tx_hi;

   // Entry values and counter helpers.
   always_comb begin
      entry_limit = (i_memory_size == '0) ? {1'b1, {ADDR_SIZE{1'b0}}} : {1'b0, i_memory_size};
      entry_dec   = (i_decimator == '0) ? DECIMATOR_SIZE'(1) : i_decimator;
      count_inc   = count_q + CntW'(1);
      last_word   = (count_inc == limit_q);
      dec_cnt_inc = dec_cnt_q + DECIMATOR_SIZE'(1);
      dec_wrap    = (dec_cnt_inc == dec_n_q);
      tx_hi       = TX_SIZE'(i_mem_rdata[DATA_SIZE-1:8]);
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= StIdle;
         op_q         <= '0;
         limit_q      <= '0;
         count_q      <= '0;
         dec_n_q      <= '0;
         dec_cnt_q    <= '0;
         lo_byte_q    <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         sample_end_q <= 1'b0;
         dump_end_q   <= 1'b0;
         clean_end_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         mem_we_q     <= 1'b0;
         sample_end_q <= 1'b0;
         dump_end_q   <= 1'b0;
         clean_end_q  <= 1'b0;
         if (state_q != StIdle && i_status != op_q) begin
            // Abort or normal exit from DONE: nothing further is written or sent.
            state_q    <= StIdle;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  // Parameters are latched every idle cycle; only the matching one sticks.
                  op_q      <= i_status;
                  limit_q   <= entry_limit;
                  dec_n_q   <= entry_dec;
                  dec_cnt_q <= '0;
                  count_q   <= '0;
                  case (i_status)
                     CodeSample: begin
                        state_q <= StCapture;
                        busy_q  <= 1'b1;
                     end
                     CodeDump: begin
                        state_q    <= StDumpRd;
                        busy_q     <= 1'b1;
                        mem_addr_q <= '0;
                     end
                     CodeClean: begin
                        state_q <= StClean;
                        busy_q  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               StCapture: begin
                  if (i_adc_valid) begin
                     dec_cnt_q <= dec_wrap ? '0 : dec_cnt_inc;
                     if (dec_cnt_q == '0) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= count_q[ADDR_SIZE-1:0];
                        mem_wdata_q <= i_adc_data;
                        count_q     <= count_inc;
                        if (last_word) begin
                           sample_end_q <= 1'b1;
                           state_q      <= StDone;
                        end
                     end
                  end
               end
               StClean: begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= count_q[ADDR_SIZE-1:0];
                  mem_wdata_q <= '0;
                  count_q     <= count_inc;
                  if (last_word) begin
                     clean_end_q <= 1'b1;
                     state_q     <= StDone;
                  end
               end
               StDumpRd: begin
                  state_q <= StDumpWait;
               end
               StDumpWait: begin
                  lo_byte_q  <= i_mem_rdata[7:0];
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= tx_hi;
                  state_q    <= StDumpHi;
               end
               StDumpHi: begin
                  if (i_tx_ready) begin
                     tx_data_q <= TX_SIZE'(lo_byte_q);
                     state_q   <= StDumpLo;
                  end
               end
               StDumpLo: begin
                  if (i_tx_ready) begin
                     tx_valid_q <= 1'b0;
                     if (last_word) begin
                        dump_end_q <= 1'b1;
                        state_q    <= StDone;
                     end else begin
                        count_q    <= count_inc;
                        mem_addr_q <= count_inc[ADDR_SIZE-1:0];
                        state_q    <= StDumpRd;
                     end
                  end
               end
               StDone: ;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_tx_valid   = tx_valid_q;
   assign o_tx_data    = tx_data_q;
   assign o_sample_end = sample_end_q;
   assign o_dump_end   = dump_end_q;
   assign o_clean_end  = clean_end_q;
   assign o_busy       = busy_q;

endmodule
